datapath_ctrl: RTL and testbench

- Moore FSM that sequences the 16-bit register-file/ALU datapath: one instruction at a time, one datapath step per cycle.
- Latches a 16-bit instruction on `start` and decodes it.
- Drives every datapath control input and the datapath write-data value.
- Sits between the instruction source (switches/testbench, later the fetch unit) and the datapath.

---
 rtl/datapath_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_datapath_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_ctrl.sv
// datapath_ctrl: Moore sequencer for the 16-bit register-file/ALU datapath.
// Latches one instruction on start, decodes it and steps the datapath one
// state per cycle. All control outputs are registered.
// Optional: define ILLEGAL_TRAP_EN to add the sticky `illegal` flag and a done
// pulse on unsupported encodings; without it those encodings return silently.
module datapath_ctrl #(
    parameter int IW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [IW-1:0] instr,
    output logic          waiting,
    output logic          done,
    output logic [DW-1:0] datapath_in,
    output logic          wb_sel,
    output logic [2:0]    w_addr,
    output logic          w_en,
    output logic [2:0]    r_addr,
    output logic          en_A,
    output logic          en_B,
    output logic [1:0]    shift_op,
    output logic          sel_A,
    output logic          sel_B,
    output logic [1:0]    ALU_op,
    output logic          en_C,
`ifdef ILLEGAL_TRAP_EN
    output logic          illegal,
`endif
    output logic          en_status
);

    typedef enum logic [2:0] {
        StWait, StDecode, StLoadA, StLoadB, StCalc, StWrImm, StWrReg
    } state_e;

    typedef enum logic [2:0] {
        KMovImm, KMovReg, KMvn, KAdd, KCmp, KAnd, KIllegal
    } kind_e;

    // Classify from the opc/op header bits [15:11].
    function automatic kind_e classify(input logic [4:0] hdr);
        kind_e k;
        k = KIllegal;
        if (hdr == 5'b110_10) begin
            k = KMovImm;
        end else if (hdr == 5'b110_00) begin
            k = KMovReg;
        end else if (hdr[4:2] == 3'b101) begin
            case (hdr[1:0])
                2'b00:   k = KAdd;
                2'b01:   k = KCmp;
                2'b10:   k = KAnd;
                default: k = KMvn;
            endcase
        end
        return k;
    endfunction

    state_e        state_q, state_d;
    logic [IW-1:0] ir_q, ir_d;
    kind_e         kind_q, kind_d;

    logic       waiting_d, done_d, wb_sel_d, w_en_d;
    logic [2:0] w_addr_d, r_addr_d;
    logic       en_A_d, en_B_d, sel_A_d, en_C_d, en_status_d;
    logic [1:0] shift_op_d, ALU_op_d;

    assign kind_q      = classify(ir_q[15:11]);
    assign kind_d      = classify(ir_d[15:11]);
    assign datapath_in = {{(DW-8){ir_q[7]}}, ir_q[7:0]};
    assign sel_B       = 1'b0;

    // Next state and instruction register; start only matters in WAIT.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            StWait: begin
                if (start) begin
                    state_d = StDecode;
                    ir_d    = instr;
                end
            end
            StDecode: begin
                case (kind_q)
                    KMovImm:             state_d = StWrImm;
                    KMovReg, KMvn:       state_d = StLoadB;
                    KAdd, KCmp, KAnd:    state_d = StLoadA;
                    default:             state_d = StWait;
                endcase
            end
            StLoadA: state_d = StLoadB;
            StLoadB: state_d = StCalc;
            StCalc:  state_d = (kind_q == KCmp) ? StWait : StWrReg;
            default: state_d = StWait;
        endcase
    end

    // Outputs for the state being entered, so they come straight from flops.
    always_comb begin
        waiting_d   = 1'b0;
        done_d      = 1'b0;
        wb_sel_d    = 1'b0;
        w_addr_d    = 3'd0;
        w_en_d      = 1'b0;
        r_addr_d    = 3'd0;
        en_A_d      = 1'b0;
        en_B_d      = 1'b0;
        shift_op_d  = 2'b00;
        sel_A_d     = 1'b0;
        ALU_op_d    = 2'b00;
        en_C_d      = 1'b0;
        en_status_d = 1'b0;
        case (state_d)
            StWait: waiting_d = 1'b1;
            StDecode: begin
`ifdef ILLEGAL_TRAP_EN
                done_d = (kind_d == KIllegal);
`endif
            end
            StLoadA: begin
                r_addr_d = ir_d[10:8];
                en_A_d   = 1'b1;
            end
            StLoadB: begin
                r_addr_d = ir_d[2:0];
                en_B_d   = 1'b1;
            end
            StCalc: begin
                shift_op_d  = ir_d[4:3];
                ALU_op_d    = (kind_d == KMovReg) ? 2'b00 : ir_d[12:11];
                sel_A_d     = (kind_d == KMovReg) || (kind_d == KMvn);
                en_C_d      = (kind_d != KCmp);
                en_status_d = (kind_d == KCmp);
                done_d      = (kind_d == KCmp);
            end
            StWrImm: begin
                wb_sel_d = 1'b1;
                w_addr_d = ir_d[10:8];
                w_en_d   = 1'b1;
                done_d   = 1'b1;
            end
            StWrReg: begin
                w_addr_d = ir_d[7:5];
                w_en_d   = 1'b1;
                done_d   = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_d;

    // Sticky trap: set after an illegal decode, cleared by a legal accept.
    always_comb begin
        illegal_d = illegal;
        if (state_q == StWait && start) begin
            if (kind_d != KIllegal) illegal_d = 1'b0;
        end else if (state_q == StDecode && kind_q == KIllegal) begin
            illegal_d = 1'b1;
        end
    end

    // Trap flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) illegal <= 1'b0;
        else     illegal <= illegal_d;
    end
`endif

    // State, instruction and registered control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StWait;
            ir_q      <= '0;
            waiting   <= 1'b1;
            done      <= 1'b0;
            wb_sel    <= 1'b0;
            w_addr    <= 3'd0;
            w_en      <= 1'b0;
            r_addr    <= 3'd0;
            en_A      <= 1'b0;
            en_B      <= 1'b0;
            shift_op  <= 2'b00;
            sel_A     <= 1'b0;
            ALU_op    <= 2'b00;
            en_C      <= 1'b0;
            en_status <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            waiting   <= waiting_d;
            done      <= done_d;
            wb_sel    <= wb_sel_d;
            w_addr    <= w_addr_d;
            w_en      <= w_en_d;
            r_addr    <= r_addr_d;
            en_A      <= en_A_d;
            en_B      <= en_B_d;
            shift_op  <= shift_op_d;
            sel_A     <= sel_A_d;
            ALU_op    <= ALU_op_d;
            en_C      <= en_C_d;
            en_status <= en_status_d;
        end
    end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Testbench for datapath_ctrl: directed instructions plus randomized ones,
// each checked cycle by cycle against a phase-list reference model.
module tb_datapath_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] instr;
    logic        waiting, done, wb_sel, w_en, en_A, en_B, sel_A, sel_B, en_C, en_status;
    logic [15:0] datapath_in;
    logic [2:0]  w_addr, r_addr;
    logic [1:0]  shift_op, ALU_op;
`ifdef ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    datapath_ctrl #(.IW(16), .DW(16)) dut (
        .clk(clk), .rst(rst), .start(start), .instr(instr),
        .waiting(waiting), .done(done), .datapath_in(datapath_in),
        .wb_sel(wb_sel), .w_addr(w_addr), .w_en(w_en), .r_addr(r_addr),
        .en_A(en_A), .en_B(en_B), .shift_op(shift_op), .sel_A(sel_A),
        .sel_B(sel_B), .ALU_op(ALU_op), .en_C(en_C),
`ifdef ILLEGAL_TRAP_EN
        .illegal(illegal),
`endif
        .en_status(en_status)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit ill_exp = 1'b0;

    typedef struct packed {
        logic       waiting, done, wb_sel;
        logic [2:0] w_addr;
        logic       w_en;
        logic [2:0] r_addr;
        logic       en_a, en_b;
        logic [1:0] shift_op;
        logic       sel_a, sel_b;
        logic [1:0] alu_op;
        logic       en_c, en_status;
    } ctl_t;

    localparam int PWait = 0, PDec = 1, PLa = 2, PLb = 3, PCalc = 4, PWi = 5, PWr = 6;
    localparam int KMovImm = 0, KMovReg = 1, KMvn = 2, KAdd = 3, KCmp = 4, KAnd = 5, KIll = 6;

    function automatic int kind_of(input logic [15:0] i);
        if (i[15:13] == 3'b110 && i[12:11] == 2'b10) return KMovImm;
        if (i[15:13] == 3'b110 && i[12:11] == 2'b00) return KMovReg;
        if (i[15:13] == 3'b101) begin
            if (i[12:11] == 2'b00) return KAdd;
            if (i[12:11] == 2'b01) return KCmp;
            if (i[12:11] == 2'b10) return KAnd;
            return KMvn;
        end
        return KIll;
    endfunction

    // Cycles after the start edge, one entry per cycle up to the done cycle.
    function automatic int n_phases(input int k);
        case (k)
            KMovImm:         return 2;
            KMovReg, KMvn:   return 4;
            KAdd, KAnd:      return 5;
            KCmp:            return 4;
            default:         return 1;
        endcase
    endfunction

    function automatic int phase_at(input int k, input int n);
        int seq[5];
        case (k)
            KMovImm:       seq = '{PDec, PWi, PWait, PWait, PWait};
            KMovReg, KMvn: seq = '{PDec, PLb, PCalc, PWr, PWait};
            KAdd, KAnd:    seq = '{PDec, PLa, PLb, PCalc, PWr};
            KCmp:          seq = '{PDec, PLa, PLb, PCalc, PWait};
            default:       seq = '{PDec, PWait, PWait, PWait, PWait};
        endcase
        return seq[n];
    endfunction

    function automatic logic [15:0] sext(input logic [15:0] i);
        byte b;
        int  v;
        b = i[7:0];
        v = b;
        return v[15:0];
    endfunction

    function automatic ctl_t expect_ctl(input logic [15:0] i, input int ph);
        ctl_t e;
        int   k;
        e = '0;
        k = kind_of(i);
        case (ph)
            PWait: e.waiting = 1'b1;
            PDec: begin
`ifdef ILLEGAL_TRAP_EN
                e.done = (k == KIll);
`endif
            end
            PLa: begin e.r_addr = i[10:8]; e.en_a = 1'b1; end
            PLb: begin e.r_addr = i[2:0];  e.en_b = 1'b1; end
            PCalc: begin
                e.shift_op  = i[4:3];
                e.alu_op    = (k == KMovReg) ? 2'b00 : i[12:11];
                e.sel_a     = (k == KMovReg || k == KMvn);
                e.en_c      = (k != KCmp);
                e.en_status = (k == KCmp);
                e.done      = (k == KCmp);
            end
            PWi: begin e.wb_sel = 1'b1; e.w_addr = i[10:8]; e.w_en = 1'b1; e.done = 1'b1; end
            PWr: begin e.w_addr = i[7:5]; e.w_en = 1'b1; e.done = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic ctl_t observed();
        ctl_t o;
        o.waiting = waiting;   o.done = done;       o.wb_sel = wb_sel;
        o.w_addr = w_addr;     o.w_en = w_en;       o.r_addr = r_addr;
        o.en_a = en_A;         o.en_b = en_B;       o.shift_op = shift_op;
        o.sel_a = sel_A;       o.sel_b = sel_B;     o.alu_op = ALU_op;
        o.en_c = en_C;         o.en_status = en_status;
        return o;
    endfunction

    function automatic logic [15:0] rand_instr(input int k);
        logic [15:0] r;
        r = 16'($urandom);
        case (k)
            KMovImm: r[15:11] = 5'b110_10;
            KMovReg: r[15:11] = 5'b110_00;
            KMvn:    r[15:11] = 5'b101_11;
            KAdd:    r[15:11] = 5'b101_00;
            KCmp:    r[15:11] = 5'b101_01;
            KAnd:    r[15:11] = 5'b101_10;
            default: while (kind_of(r) != KIll) r = 16'($urandom);
        endcase
        return r;
    endfunction

    // Launch one instruction from a WAIT-cycle negedge and check every cycle
    // through the following WAIT cycle. instr is scrambled after launch.
    task automatic exec(input logic [15:0] i, input bit keep_start, input string tag);
        int   k;
        ctl_t exp, act;
        k = kind_of(i);
        start = 1'b1;
        instr = i;
        for (int p = 0; p <= n_phases(k); p++) begin
            @(negedge clk);
            start = keep_start;
            instr = 16'($urandom);
            if (p == 0 && k != KIll) ill_exp = 1'b0;
            exp = (p == n_phases(k)) ? expect_ctl(i, PWait) : expect_ctl(i, phase_at(k, p));
            act = observed();
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL %s cycle%0d instr=%h ctl got=%h want=%h", tag, p + 1, i, act, exp);
            end
            checks++;
            if (datapath_in !== sext(i)) begin
                errors++;
                $display("FAIL %s cycle%0d datapath_in got=%h want=%h", tag, p + 1, datapath_in,
                         sext(i));
            end
`ifdef ILLEGAL_TRAP_EN
            checks++;
            if (illegal !== ill_exp) begin
                errors++;
                $display("FAIL %s cycle%0d illegal got=%b want=%b", tag, p + 1, illegal, ill_exp);
            end
`endif
            if (p == 0 && k == KIll) ill_exp = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        instr = 16'hA148;
        repeat (2) @(negedge clk);
        checks++;
        if (observed() !== expect_ctl(16'h0, PWait)) begin
            errors++;
            $display("FAIL reset ctl got=%h want=%h", observed(), expect_ctl(16'h0, PWait));
        end
        checks++;
        if (datapath_in !== 16'h0000) begin
            errors++;
            $display("FAIL reset datapath_in got=%h want=0000", datapath_in);
        end
`ifdef ILLEGAL_TRAP_EN
        checks++;
        if (illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset illegal got=%b want=0", illegal);
        end
`endif
        rst = 1'b0;
        ill_exp = 1'b0;
        @(negedge clk);
        checks++;
        if (waiting !== 1'b1) begin
            errors++;
            $display("FAIL reset_release waiting got=%b want=1", waiting);
        end
    endtask

    task automatic test_directed();
        exec(16'hD3FB, 1'b0, "mov_imm");
        exec(16'hA148, 1'b0, "add");
        exec(16'hA900, 1'b0, "cmp");
        exec(16'hB887, 1'b0, "mvn");
        exec(16'hC0E3, 1'b0, "mov_reg");
        exec(16'hB65D, 1'b0, "and");
    endtask

    task automatic test_illegal();
        exec(16'hE000, 1'b0, "illegal");
        exec(16'h0123, 1'b0, "illegal2");
        exec(16'hD27F, 1'b0, "legal_after_illegal");
    endtask

    task automatic test_idle();
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (observed() !== expect_ctl(16'h0, PWait)) begin
                errors++;
                $display("FAIL idle cycle%0d ctl got=%h want=%h", c, observed(),
                         expect_ctl(16'h0, PWait));
            end
        end
    endtask

    // start held high: ignored while busy, relaunches after one WAIT cycle.
    task automatic test_back_to_back();
        exec(16'hA148, 1'b1, "b2b_add");
        exec(16'hD3FB, 1'b1, "b2b_mov_imm");
        exec(16'hA900, 1'b1, "b2b_cmp");
        exec(16'hB887, 1'b1, "b2b_mvn");
        start = 1'b0;
        test_idle();
    endtask

    task automatic test_abort();
        ctl_t want;
        start = 1'b1;
        instr = 16'hA148;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        want = expect_ctl(16'hA148, PLb);
        checks++;
        if (observed() !== want) begin
            errors++;
            $display("FAIL abort_load_b ctl got=%h want=%h", observed(), want);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (observed() !== expect_ctl(16'h0, PWait) || datapath_in !== 16'h0000) begin
            errors++;
            $display("FAIL abort_async ctl got=%h want=%h dp=%h", observed(),
                     expect_ctl(16'h0, PWait), datapath_in);
        end
        @(negedge clk);
        rst = 1'b0;
        ill_exp = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (w_en !== 1'b0 || waiting !== 1'b1) begin
                errors++;
                $display("FAIL abort_after cycle%0d w_en got=%b want=0 waiting got=%b want=1",
                         c, w_en, waiting);
            end
        end
        exec(16'hA148, 1'b0, "add_after_abort");
    endtask

    task automatic test_random();
        logic [15:0] i;
        for (int n = 0; n < 40; n++) begin
            i = rand_instr(int'($urandom_range(0, 6)));
            exec(i, 1'(($urandom & 3) == 0), "random");
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_idle();
        test_illegal();
        test_back_to_back();
        test_abort();
        test_random();
        test_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
